// File: rtl/fp_norm_pkg.sv
// Shared widths, sentinel and per-stage payload for the mantissa normalizer.
// Payload widths are fixed here; the top's parameters default to the same values.
package fp_norm_pkg;

   localparam int MANT_W = 96;
   localparam int EXP_W  = 16;
   localparam int POS_W  = 7;
   localparam int TAG_W  = 8;

   // Find-first-one reports all-ones when the mantissa has no set bit.
   localparam int NO_ONE = 2**POS_W - 1;

   function automatic int shift_width(input int mw);
      return $clog2(mw);
   endfunction

   localparam int SHIFT_W = shift_width(MANT_W);

   typedef struct packed {
      logic [MANT_W-1:0]  mant;
      logic [EXP_W-1:0]   exp;
      logic [SHIFT_W-1:0] shift;
      logic               zero;
      logic               denorm;
      logic [TAG_W-1:0]   tag;
   } stage_payload_t;

   localparam int PAYLOAD_W = $bits(stage_payload_t);

endpackage

// File: rtl/fp_norm_stage_reg.sv
// One handshaked pipeline register: payload plus valid bit, loaded when its ready is high.
module fp_norm_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_reg;
   logic [W-1:0] data_reg;

   // Data only captures on a real beat, so a drained stage keeps its last payload.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (load_i) begin
         valid_reg <= valid_i;
         if (valid_i) begin
            data_reg <= data_i;
         end
      end
   end

   assign valid_o = valid_reg;
   assign data_o  = data_reg;

endmodule

// File: rtl/fp_norm_shift.sv
// Three-stage normalizer: decode shift/exponent, coarse byte shift, fine bit shift.
// Handles zero and denormal results; valid/ready chained back from the output.
module fp_norm_shift
   import fp_norm_pkg::*;
#(
   parameter int MW   = MANT_W,
   parameter int EW   = EXP_W,
   parameter int POSW = POS_W,
   parameter int TW   = TAG_W
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [MW-1:0]   mant_i,
   input  logic [EW-1:0]   exp_i,
   input  logic [POSW-1:0] pos_i,
   input  logic [TW-1:0]   tag_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [MW-1:0]   mant_o,
   output logic [EW-1:0]   exp_o,
   output logic            zero_o,
   output logic            denorm_o,
   output logic [TW-1:0]   tag_o
);

   localparam int SW     = shift_width(MW);
   localparam int NSTAGE = 3;

   stage_payload_t    stage_in  [NSTAGE];
   stage_payload_t    stage_out [NSTAGE];
   logic [NSTAGE-1:0] stage_vin;
   logic [NSTAGE-1:0] stage_v;
   logic [NSTAGE-1:0] stage_load;

   logic              rdy_s1;
   logic              rdy_s2;
   logic              rdy_s3;
   logic              zero_dec;
   logic [SW-1:0]     sh_dec;

   // A stage may load when it is empty or the stage after it is draining.
   always_comb begin
      rdy_s3     = !stage_v[2] || ready_i;
      rdy_s2     = !stage_v[1] || rdy_s3;
      rdy_s1     = !stage_v[0] || rdy_s2;
      stage_load = {rdy_s3, rdy_s2, rdy_s1};
      stage_vin  = {stage_v[1], stage_v[0], valid_i};
   end

   assign ready_o = rdy_s1;

   always_comb begin
      zero_dec = (32'(pos_i) == NO_ONE) || (32'(pos_i) > MW - 1);
      sh_dec   = SW'(MW - 1) - SW'(pos_i);

      stage_in[0]     = '0;
      stage_in[0].tag = tag_i;
      if (zero_dec) begin
         stage_in[0].zero = 1'b1;
      end else if (exp_i > EW'(sh_dec)) begin
         stage_in[0].mant  = mant_i;
         stage_in[0].shift = sh_dec;
         stage_in[0].exp   = exp_i - EW'(sh_dec);
      end else begin
         // Exponent would underflow: shift only as far as exponent 1 allows, then
         // report the denormal encoding (exp 0) with the implied shift of one less.
         stage_in[0].mant   = mant_i;
         stage_in[0].denorm = 1'b1;
         stage_in[0].shift  = (exp_i == '0) ? '0 : SW'(exp_i - EW'(1));
      end

      stage_in[1]      = stage_out[0];
      stage_in[1].mant = stage_out[0].mant << {stage_out[0].shift[SW-1:3], 3'b000};

      stage_in[2]      = stage_out[1];
      stage_in[2].mant = stage_out[1].mant << stage_out[1].shift[2:0];
   end

   for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      fp_norm_stage_reg #(
         .W (PAYLOAD_W)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .load_i  (stage_load[gi]),
         .valid_i (stage_vin[gi]),
         .data_i  (stage_in[gi]),
         .valid_o (stage_v[gi]),
         .data_o  (stage_out[gi])
      );
   end

   assign valid_o  = stage_v[2];
   assign mant_o   = stage_out[2].mant;
   assign exp_o    = stage_out[2].exp;
   assign zero_o   = stage_out[2].zero;
   assign denorm_o = stage_out[2].denorm;
   assign tag_o    = stage_out[2].tag;

endmodule
